// File: rtl/ysyx_22050612_pkg.sv
// Shared types and constants for the multi-cycle NPC sequencer.
package ysyx_22050612_pkg;

  typedef enum logic [2:0] {
    ST_FETCH_REQ  = 3'd0,
    ST_FETCH_WAIT = 3'd1,
    ST_EXEC       = 3'd2,
    ST_WB         = 3'd3,
    ST_HALT       = 3'd4,
    ST_FAULT      = 3'd5
  } state_e;

  localparam logic [31:0] NOP_INST     = 32'h0000_0013;
  localparam int unsigned DEF_XLEN     = 64;
  localparam logic [63:0] DEF_RESET_PC = 64'h8000_0000;

endpackage

// File: rtl/ysyx_22050612_timeout_ctr.sv
// Down-counter watchdog: loads LIMIT-1 on clear, expires when it reaches zero
// while enabled. LIMIT of 0 disables expiry entirely.
module ysyx_22050612_timeout_ctr #(
  parameter int LIMIT = 256
) (
  input  logic clk,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [W-1:0] LOAD = (LIMIT > 0) ? W'(LIMIT - 1) : '0;
  localparam logic ENABLED = (LIMIT != 0);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = LOAD;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  assign expire = ENABLED && en && !clr && (cnt_q == '0);

endmodule

// File: rtl/ysyx_22050612_npc_mc.sv
// Multi-cycle NPC sequencer: fetch over valid/ready imem, hand the instruction
// to the IDU/EXU datapath, wait for done, write back and advance pc.
module ysyx_22050612_npc_mc
  import ysyx_22050612_pkg::*;
#(
  parameter int unsigned XLEN     = DEF_XLEN,
  parameter logic [63:0] RESET_PC = DEF_RESET_PC,
  parameter int          TIMEOUT  = 256,
  parameter int unsigned CNT_W    = 64
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [XLEN-1:0]  imem_req_addr,
  input  logic             imem_rsp_valid,
  input  logic [31:0]      imem_rsp_data,
  input  logic             imem_rsp_err,
  output logic [31:0]      inst,
  output logic             exu_start,
  input  logic             exu_done,
  input  logic [XLEN-1:0]  exu_dnpc,
  input  logic             exu_halt,
  output logic             wb_en,
  output logic [XLEN-1:0]  pc,
  output logic             commit,
  output logic [CNT_W-1:0] retired,
  output logic             halted,
  output logic             fault
);

  state_e           state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  dnpc_q, dnpc_d;
  logic [31:0]      inst_q, inst_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             exu_start_q, exu_start_d;
  logic             wb_en_q, wb_en_d;
  logic             commit_q, commit_d;
  logic             tmo_expire;

  ysyx_22050612_timeout_ctr #(
    .LIMIT (TIMEOUT)
  ) u_tmo (
    .clk    (clk),
    .clr    (state_q != ST_FETCH_WAIT),
    .en     (state_q == ST_FETCH_WAIT),
    .expire (tmo_expire)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    dnpc_d      = dnpc_q;
    inst_d      = inst_q;
    retired_d   = retired_q;
    exu_start_d = 1'b0;
    wb_en_d     = 1'b0;
    commit_d    = 1'b0;
    case (state_q)
      ST_FETCH_REQ: begin
        if (imem_req_ready) state_d = ST_FETCH_WAIT;
      end
      // A response arriving in the expiry cycle still wins over the timeout.
      ST_FETCH_WAIT: begin
        if (imem_rsp_valid) begin
          if (imem_rsp_err) begin
            state_d = ST_FAULT;
          end else begin
            inst_d      = imem_rsp_data;
            exu_start_d = 1'b1;
            state_d     = ST_EXEC;
          end
        end else if (tmo_expire) begin
          state_d = ST_FAULT;
        end
      end
      ST_EXEC: begin
        if (exu_done) begin
          if (exu_halt) begin
            commit_d  = 1'b1;
            retired_d = retired_q + CNT_W'(1);
            state_d   = ST_HALT;
          end else if (exu_dnpc[1:0] != 2'b00) begin
            state_d = ST_FAULT;
          end else begin
            dnpc_d   = exu_dnpc;
            wb_en_d  = 1'b1;
            commit_d = 1'b1;
            state_d  = ST_WB;
          end
        end
      end
      ST_WB: begin
        pc_d      = dnpc_q;
        retired_d = retired_q + CNT_W'(1);
        state_d   = ST_FETCH_REQ;
      end
      ST_HALT, ST_FAULT: begin
        state_d = state_q;
      end
      default: state_d = ST_FAULT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_FETCH_REQ;
      pc_q        <= XLEN'(RESET_PC);
      inst_q      <= NOP_INST;
      retired_q   <= '0;
      exu_start_q <= 1'b0;
      wb_en_q     <= 1'b0;
      commit_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      inst_q      <= inst_d;
      retired_q   <= retired_d;
      exu_start_q <= exu_start_d;
      wb_en_q     <= wb_en_d;
      commit_q    <= commit_d;
    end
    dnpc_q <= dnpc_d;
  end

  assign imem_req_valid = (state_q == ST_FETCH_REQ);
  assign imem_req_addr  = pc_q;
  assign inst           = inst_q;
  assign exu_start      = exu_start_q;
  assign wb_en          = wb_en_q;
  assign commit         = commit_q;
  assign pc             = pc_q;
  assign retired        = retired_q;
  assign halted         = (state_q == ST_HALT);
  assign fault          = (state_q == ST_FAULT);

endmodule

// File: tb/tb_ysyx_22050612_npc_mc.sv
// Scoreboard bench for the multi-cycle NPC: the bench plays imem and EXU,
// tracks the architectural pc/retired count, and checks every commit.
module tb_ysyx_22050612_npc_mc;

  localparam int          XLEN = 64;
  localparam logic [63:0] RPC  = 64'h8000_0000;
  localparam int          TMO  = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             imem_req_valid;
  logic             imem_req_ready = 1'b0;
  logic [XLEN-1:0]  imem_req_addr;
  logic             imem_rsp_valid = 1'b0;
  logic [31:0]      imem_rsp_data = 32'h0;
  logic             imem_rsp_err = 1'b0;
  logic [31:0]      inst;
  logic             exu_start;
  logic             exu_done = 1'b0;
  logic [XLEN-1:0]  exu_dnpc = '0;
  logic             exu_halt = 1'b0;
  logic             wb_en;
  logic [XLEN-1:0]  pc;
  logic             commit;
  logic [63:0]      retired;
  logic             halted;
  logic             fault;

  ysyx_22050612_npc_mc #(
    .XLEN(XLEN), .RESET_PC(RPC), .TIMEOUT(TMO), .CNT_W(64)
  ) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .imem_rsp_err(imem_rsp_err),
    .inst(inst), .exu_start(exu_start), .exu_done(exu_done),
    .exu_dnpc(exu_dnpc), .exu_halt(exu_halt), .wb_en(wb_en), .pc(pc),
    .commit(commit), .retired(retired), .halted(halted), .fault(fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] pc;
    logic        wb;
  } exp_t;

  exp_t        exp_q[$];
  int          total = 0;
  int          bad = 0;
  logic [63:0] m_pc = RPC;
  logic [63:0] m_ret = 64'd0;
  bit          chk_period = 1'b0;
  longint      cyc = 0;
  longint      last_commit = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Monitor: every commit pulse must match the oldest expected retirement.
  always @(negedge clk) begin
    if (!rst) begin
      if (commit) begin
        if (exp_q.size() == 0) begin
          check("unexpected_commit", 64'(commit), 64'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("commit_pc", pc, e.pc);
          check("commit_wb_en", 64'(wb_en), 64'(e.wb));
          if (chk_period && last_commit >= 0)
            check("commit_period", 64'(cyc - last_commit), 64'd4);
          last_commit = cyc;
        end
      end else if (wb_en) begin
        check("wb_en_without_commit", 64'(wb_en), 64'd0);
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_err = 1'b0;
    exu_done = 1'b0; exu_halt = 1'b0;
    @(negedge clk);
    check("rst_pc", pc, RPC);
    check("rst_inst", 64'(inst), 64'h13);
    check("rst_retired", retired, 64'd0);
    check("rst_halted", 64'(halted), 64'd0);
    check("rst_fault", 64'(fault), 64'd0);
    check("rst_exu_start", 64'(exu_start), 64'd0);
    check("rst_wb_en", 64'(wb_en), 64'd0);
    check("rst_commit", 64'(commit), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    m_pc = RPC; m_ret = 64'd0; chk_period = 1'b0; last_commit = -1;
  endtask

  task automatic wait_req(output bit ok);
    int n = 0;
    while (!imem_req_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    ok = imem_req_valid;
    if (!ok) check("req_wait_timeout", 64'(imem_req_valid), 64'd1);
  endtask

  // One instruction; rsp_lat < 0 means imem never answers.
  task automatic do_instr(input int rdy_lat, input int rsp_lat, input int exu_lat,
                          input bit err, input bit halt,
                          input logic [63:0] dnpc, input logic [31:0] word);
    bit ok;
    exp_t e;
    wait_req(ok);
    if (!ok) return;
    check("retired", retired, m_ret);
    check("req_addr", imem_req_addr, m_pc);
    for (int i = 0; i < rdy_lat; i++) begin
      imem_req_ready = 1'b0;
      imem_rsp_valid = (i == 0);
      imem_rsp_data  = 32'hdead_beef;
      @(negedge clk);
      imem_rsp_valid = 1'b0;
      check("req_hold_valid", 64'(imem_req_valid), 64'd1);
      check("req_hold_addr", imem_req_addr, m_pc);
    end
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    check("req_drop", 64'(imem_req_valid), 64'd0);
    if (rsp_lat < 0) begin
      for (int i = 0; i < TMO - 1; i++) begin
        @(negedge clk);
        check("tmo_early", 64'(fault), 64'd0);
      end
      @(negedge clk);
      check("tmo_fault", 64'(fault), 64'd1);
      check("tmo_pc", pc, m_pc);
      return;
    end
    for (int i = 0; i < rsp_lat; i++) begin
      exu_done = 1'b1; exu_halt = 1'b1;
      @(negedge clk);
      check("wait_no_start", 64'(exu_start), 64'd0);
    end
    exu_done = 1'b0; exu_halt = 1'b0;
    imem_rsp_valid = 1'b1; imem_rsp_data = word; imem_rsp_err = err;
    @(negedge clk);
    imem_rsp_valid = 1'b0; imem_rsp_err = 1'b0;
    if (err) begin
      check("err_fault", 64'(fault), 64'd1);
      check("err_pc", pc, m_pc);
      return;
    end
    check("exu_start", 64'(exu_start), 64'd1);
    check("inst", 64'(inst), 64'(word));
    check("exec_pc", pc, m_pc);
    for (int i = 0; i < exu_lat; i++) begin
      @(negedge clk);
      check("start_one_cycle", 64'(exu_start), 64'd0);
      check("exec_inst_stable", 64'(inst), 64'(word));
    end
    if (halt || dnpc[1:0] == 2'b00) begin
      e.pc = m_pc; e.wb = !halt;
      exp_q.push_back(e);
    end
    exu_done = 1'b1; exu_halt = halt; exu_dnpc = dnpc;
    @(negedge clk);
    exu_done = 1'b0; exu_halt = 1'b0;
    if (halt) begin
      m_ret = m_ret + 64'd1;
      check("halted", 64'(halted), 64'd1);
      check("halt_retired", retired, m_ret);
      check("halt_pc", pc, m_pc);
    end else if (dnpc[1:0] != 2'b00) begin
      check("misalign_fault", 64'(fault), 64'd1);
      check("misalign_pc", pc, m_pc);
    end else begin
      check("wb_en", 64'(wb_en), 64'd1);
      m_ret = m_ret + 64'd1;
      m_pc  = dnpc;
    end
  endtask

  task automatic idle_check(input int n, input logic [63:0] hold_pc);
    imem_req_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("idle_no_req", 64'(imem_req_valid), 64'd0);
      check("idle_pc", pc, hold_pc);
    end
    imem_req_ready = 1'b0;
  endtask

  initial begin
    bit ok;
    logic [63:0] d;
    do_reset();

    chk_period = 1'b1;
    for (int i = 0; i < 3; i++) do_instr(0, 0, 0, 0, 0, m_pc + 64'd4, 32'h0000_0013);
    chk_period = 1'b0;
    wait_req(ok);
    check("retired_after_3", retired, m_ret);
    check("pc_after_3", pc, RPC + 64'd12);

    do_instr(5, 1, 1, 0, 0, m_pc + 64'd4, $urandom);

    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 3) == 0) d = RPC + 64'($urandom_range(0, 1023)) * 64'd4;
      else d = m_pc + 64'd4;
      do_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, TMO - 1)),
               int'($urandom_range(0, 3)), 0, 0, d, $urandom);
    end

    do_instr(0, 0, 1, 0, 1, m_pc + 64'd4, 32'h0010_0073);
    idle_check(6, m_pc);
    check("halt_sticky", 64'(halted), 64'd1);
    do_reset();

    do_instr(0, 0, 0, 0, 0, m_pc + 64'd4, 32'h0000_0013);
    do_instr(0, 0, 0, 0, 0, m_pc + 64'd4, 32'h0000_0013);
    check("err_target_pc", m_pc, RPC + 64'd8);
    do_instr(0, 1, 0, 1, 0, m_pc + 64'd4, 32'h0000_0013);
    idle_check(5, m_pc);
    do_reset();

    do_instr(0, -1, 0, 0, 0, m_pc + 64'd4, 32'h0000_0013);
    idle_check(3, m_pc);
    do_reset();
    do_instr(0, TMO - 1, 0, 0, 0, m_pc + 64'd4, 32'h0000_0093);

    do_reset();
    do_instr(0, 0, 0, 0, 0, RPC + 64'd2, 32'h0000_0013);
    idle_check(4, RPC);
    do_reset();

    do_instr(0, 0, 0, 0, 0, m_pc + 64'd4, 32'h0000_0013);
    do_instr(1, 2, 0, 0, 0, m_pc + 64'd4, 32'h0000_0013);
    wait_req(ok);
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0013;
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    check("mid_exec_start", 64'(exu_start), 64'd1);
    exu_done = 1'b1; exu_dnpc = m_pc + 64'd4; rst = 1'b1;
    @(negedge clk);
    exu_done = 1'b0;
    check("mid_rst_pc", pc, RPC);
    check("mid_rst_start", 64'(exu_start), 64'd0);
    check("mid_rst_wb_en", 64'(wb_en), 64'd0);
    check("mid_rst_commit", 64'(commit), 64'd0);
    check("mid_rst_retired", retired, 64'd0);
    do_reset();
    do_instr(0, 0, 0, 0, 0, m_pc + 64'd4, 32'h0000_0013);
    @(negedge clk);

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ysyx_22050612_npc_mc.md
Name: ysyx_22050612_npc_mc

Overview:
- Multi-cycle successor to the single-cycle NPC top: a core sequencer parametrised in XLEN and reset vector.
- Replaces the implicit one-instruction-per-clock flow with an explicit FSM.
- Fetches over a valid/ready instruction-memory interface with variable latency, hands the instruction to the existing decode/execute datapath, waits for a done strobe, then writes back and advances pc.
- Sits between memory and the IDU/EXU datapath; the top instantiates it in place of the direct IFU wiring.

Parameters:
- XLEN, 64, register/pc width.
- RESET_PC, 64'h8000_0000, pc value after reset (truncated to XLEN).
- TIMEOUT, 256, max cycles in FETCH_WAIT before fault; 0 disables the timeout.
- CNT_W, 64, width of the retired-instruction counter.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous active-high reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  XLEN  fetch address (= pc).
- imem_rsp_valid  in  1  fetch response valid (no backpressure).
- imem_rsp_data  in  32  fetched instruction.
- imem_rsp_err  in  1  access error, qualified by rsp_valid.
- inst  out  32  latched instruction to IDU.
- exu_start  out  1  one-cycle pulse: datapath may begin.
- exu_done  in  1  datapath finished current instruction.
- exu_dnpc  in  XLEN  next pc from EXU, sampled with exu_done.
- exu_halt  in  1  current instruction is ebreak, sampled with exu_done.
- wb_en  out  1  register-file write enable, one cycle per instruction.
- pc  out  XLEN  pc of current instruction.
- commit  out  1  one-cycle pulse per retired instruction.
- retired  out  CNT_W  retired-instruction count.
- halted  out  1  sticky, ebreak retired.
- fault  out  1  sticky, fetch error/timeout/misaligned dnpc.

Behaviour:
- Reset (sync, rst=1 at edge) dominates every state:
  - pc=RESET_PC, inst=32'h0000_0013 (nop).
  - state=FETCH_REQ, retired=0, halted=0, fault=0.
  - All pulses/valids = 0 in the cycle after reset.
- Reset mid-operation abandons any in-flight request/instruction; no commit, no wb_en.
- States: FETCH_REQ, FETCH_WAIT, EXEC, WB, HALT, FAULT.
- FETCH_REQ:
  - imem_req_valid=1, addr=pc, held stable until accepted.
  - valid&ready -> FETCH_WAIT.
  - rsp_valid in this state is ignored (stale responses dropped).
- FETCH_WAIT:
  - Timeout counter cleared on entry, increments each cycle.
  - rsp_valid&!err: inst<=rsp_data -> EXEC.
  - rsp_valid&err -> FAULT.
  - TIMEOUT!=0 and counter==TIMEOUT-1 without rsp -> FAULT. If rsp arrives in that same cycle, the response wins.
- EXEC:
  - exu_start=1 in the first EXEC cycle only; inst and pc stable throughout.
  - Wait for exu_done; it may be high in the same cycle as exu_start (1-cycle EXU).
  - exu_done from a previous instruction is not possible (EXU contract); exu_done outside EXEC is ignored.
  - On done: if exu_halt -> HALT, with commit=1 and retired+1 on the transition.
  - On done with exu_dnpc[1:0]!=0 -> FAULT, no commit.
  - Otherwise latch dnpc -> WB.
- WB (one cycle):
  - wb_en=1, commit=1.
  - pc<=latched dnpc, retired<=retired+1 (wraps at 2^CNT_W).
  - -> FETCH_REQ.
- Minimum latency per instruction: FETCH_REQ(1) + FETCH_WAIT(>=1) + EXEC(>=1) + WB(1) = 4 cycles.
- HALT: halted=1, no requests, pc holds the ebreak pc. Sticky until rst.
- FAULT: fault=1, no requests, pc holds the faulting pc. Sticky until rst.
- exu_start, wb_en and commit are registered outputs; imem_req_valid is decoded from state.

Decomposition:
- Package ysyx_22050612_pkg:
  - state enum (3-bit).
  - NOP_INST=32'h0000_0013.
  - default XLEN/RESET_PC constants.
- Sub-module ysyx_22050612_timeout_ctr: parametrised down-counter with clear, enable, expire and a disable-when-zero option.

Test Plan:
- Reset, ready=1, rsp next cycle with 32'h00000013, exu_done same cycle as start, dnpc=pc+4 -> pc steps 0x80000000, 0x80000004, ...; commit every 4 cycles; retired=3 after 3 instructions.
- imem_req_ready low 5 cycles -> req_valid stays 1 with addr constant; no state change until ready.
- Response with err=1 at pc 0x80000008 -> fault=1 next cycle; pc stays 0x80000008; no further req_valid; rst clears it.
- TIMEOUT=4, no response -> fault asserts exactly 4 cycles after FETCH_WAIT entry; with rsp on cycle 4 -> no fault, EXEC entered.
- exu_halt with exu_done after ebreak 32'h00100073 -> commit pulse, retired+1, halted=1, no wb_en, no more fetches.
- dnpc=0x80000002 -> fault, no commit; rst asserted mid-EXEC -> next cycle pc=RESET_PC, exu_start/wb_en/commit=0, retired=0.
